// File: rtl/dtc_vote_pkg.sv
// Shared types and thermometer-code helpers for the dtc_therm_vote block.
// Helpers take codes zero-extended to MAX_W bits so they work for any WIDTH up to MAX_W.
package dtc_vote_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Legal codes are an LSB-aligned run of ones: adding one clears every set bit.
    function automatic logic therm_legal(input logic [MAX_W-1:0] x);
        return (x & (x + MAX_W'(1))) == '0;
    endfunction

    function automatic logic [5:0] therm_popcount(input logic [MAX_W-1:0] x);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + {5'd0, x[i]};
        end
        return n;
    endfunction

    function automatic logic [MAX_W-1:0] therm_encode(input logic [5:0] idx);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (6'(i) < idx);
        end
        return r;
    endfunction

endpackage

// File: rtl/dtc_therm_decode.sv
// Combinational legality check and class decode of one thermometer code.
module dtc_therm_decode
    import dtc_vote_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int CLS_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] therm,
    output logic             legal,
    output logic [CLS_W-1:0] cls
);

    logic [MAX_W-1:0] therm_ext;

    assign therm_ext = MAX_W'(therm);
    assign legal     = therm_legal(therm_ext);
    assign cls       = CLS_W'(therm_popcount(therm_ext));

endmodule

// File: rtl/dtc_therm_vote.sv
// Windowed majority vote over thermometer-coded classifier output, with valid/ready result.
// Optional error counter and clear input enabled by defining DTC_THERM_VOTE_ERRCNT_EN.
module dtc_therm_vote
    import dtc_vote_pkg::*;
#(
    parameter int  WIDTH  = 7,
    parameter int  WINDOW = 8,
    localparam int CLS_W  = $clog2(WIDTH + 1),
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_therm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLS_W-1:0] out_class,
    output logic [CNT_W-1:0] out_count,
    output logic [WIDTH-1:0] out_therm,
    output logic             illegal_sticky
`ifdef DTC_THERM_VOTE_ERRCNT_EN
    ,
    input  logic             clr_err,
    output logic [7:0]       err_count
`endif
);

    localparam int                SIDX_W    = $clog2(WIDTH + 2);
    localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WINDOW - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]   votes_q [WIDTH+1];
    logic [CNT_W-1:0]   votes_d [WIDTH+1];
    logic               clear_votes;
    logic               pipe_vld_q, pipe_vld_d;
    logic               pipe_legal_q, pipe_legal_d;
    logic [CLS_W-1:0]   pipe_cls_q, pipe_cls_d;
    logic [SIDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [CLS_W-1:0]   scan_cls, cand_idx;
    logic [CNT_W-1:0]   scan_votes, cand_cnt;
    logic [CLS_W-1:0]   best_idx_q, best_idx_d;
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic [CLS_W-1:0]   out_class_q, out_class_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic [WIDTH-1:0]   out_therm_q, out_therm_d;
    logic               illegal_q, illegal_d;
    logic               dec_legal;
    logic [CLS_W-1:0]   dec_cls;
    logic               accept;

    dtc_therm_decode #(
        .WIDTH (WIDTH),
        .CLS_W (CLS_W)
    ) u_decode (
        .therm (in_therm),
        .legal (dec_legal),
        .cls   (dec_cls)
    );

    assign in_ready       = (state_q == ACCUM);
    assign out_valid      = (state_q == HOLD);
    assign accept         = in_valid && in_ready;
    assign out_class      = out_class_q;
    assign out_count      = out_count_q;
    assign out_therm      = out_therm_q;
    assign illegal_sticky = illegal_q;

    // Votes land one cycle after accept, from the registered decode.
    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_votes
            assign votes_d[gi] = clear_votes ? '0 :
                (pipe_vld_q && pipe_legal_q && (pipe_cls_q == CLS_W'(gi))) ?
                    votes_q[gi] + CNT_W'(1) : votes_q[gi];
        end
    endgenerate

    // Scan index 0 is a drain cycle for the last pipelined vote; index k examines class k-1.
    assign scan_cls = CLS_W'(scan_idx_q - SIDX_W'(1));

    always_comb begin
        scan_votes = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (scan_cls == CLS_W'(i)) begin
                scan_votes = votes_q[i];
            end
        end
    end

    always_comb begin
        cand_idx = best_idx_q;
        cand_cnt = best_cnt_q;
        if (scan_idx_q == SIDX_W'(1)) begin
            cand_idx = scan_cls;
            cand_cnt = scan_votes;
        end else if ((scan_idx_q > SIDX_W'(1)) && (scan_votes > best_cnt_q)) begin
            cand_idx = scan_cls;
            cand_cnt = scan_votes;
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        scan_idx_d   = scan_idx_q;
        best_idx_d   = best_idx_q;
        best_cnt_d   = best_cnt_q;
        out_class_d  = out_class_q;
        out_count_d  = out_count_q;
        out_therm_d  = out_therm_q;
        clear_votes  = 1'b0;
        pipe_vld_d   = accept;
        pipe_legal_d = dec_legal;
        pipe_cls_d   = dec_cls;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    if (sample_cnt_q == CNT_LAST) begin
                        state_d    = SCAN;
                        scan_idx_d = '0;
                    end
                end
            end
            SCAN: begin
                scan_idx_d = scan_idx_q + SIDX_W'(1);
                best_idx_d = cand_idx;
                best_cnt_d = cand_cnt;
                if (scan_idx_q == SIDX_LAST) begin
                    out_class_d  = cand_idx;
                    out_count_d  = cand_cnt;
                    out_therm_d  = WIDTH'(therm_encode(6'(cand_idx)));
                    clear_votes  = 1'b1;
                    sample_cnt_d = '0;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

`ifdef DTC_THERM_VOTE_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    assign err_count = err_cnt_q;

    // A clear in the same cycle as an illegal accept takes priority.
    always_comb begin
        illegal_d = illegal_q | (accept & ~dec_legal);
        err_cnt_d = err_cnt_q;
        if (accept && !dec_legal && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        if (clr_err) begin
            illegal_d = 1'b0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`else
    always_comb begin
        illegal_d = illegal_q | (accept & ~dec_legal);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            sample_cnt_q <= '0;
            pipe_vld_q   <= 1'b0;
            pipe_legal_q <= 1'b0;
            pipe_cls_q   <= '0;
            scan_idx_q   <= '0;
            best_idx_q   <= '0;
            best_cnt_q   <= '0;
            out_class_q  <= '0;
            out_count_q  <= '0;
            out_therm_q  <= '0;
            illegal_q    <= 1'b0;
            for (int i = 0; i <= WIDTH; i++) begin
                votes_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_legal_q <= pipe_legal_d;
            pipe_cls_q   <= pipe_cls_d;
            scan_idx_q   <= scan_idx_d;
            best_idx_q   <= best_idx_d;
            best_cnt_q   <= best_cnt_d;
            out_class_q  <= out_class_d;
            out_count_q  <= out_count_d;
            out_therm_q  <= out_therm_d;
            illegal_q    <= illegal_d;
            for (int i = 0; i <= WIDTH; i++) begin
                votes_q[i] <= votes_d[i];
            end
        end
    end

endmodule

// File: tb/tb_dtc_therm_vote.sv
// Self-checking bench for dtc_therm_vote (WIDTH=7, WINDOW=8) against a window-level vote model.
module tb_dtc_therm_vote;

    typedef logic [6:0] code_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    code_t      in_therm;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_class;
    logic [3:0] out_count;
    code_t      out_therm;
    logic       illegal_sticky;
`ifdef DTC_THERM_VOTE_ERRCNT_EN
    logic       clr_err;
    logic [7:0] err_count;
`endif

    int    checks = 0;
    int    errors = 0;
    bit    exp_sticky;
    code_t win [8];

    always #5 clk = ~clk;

    dtc_therm_vote #(
        .WIDTH  (7),
        .WINDOW (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_therm       (in_therm),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_class      (out_class),
        .out_count      (out_count),
        .out_therm      (out_therm),
        .illegal_sticky (illegal_sticky)
`ifdef DTC_THERM_VOTE_ERRCNT_EN
        ,
        .clr_err        (clr_err),
        .err_count      (err_count)
`endif
    );

    // A code is legal when it equals the all-ones run of its own length.
    function automatic bit ref_legal(input code_t c);
        return int'(c) == ((1 << $countones(c)) - 1);
    endfunction

    task automatic ref_vote(output int cls, output int cnt, output code_t therm);
        int votes [8];
        int t;
        for (int c = 0; c < 8; c++) votes[c] = 0;
        for (int w = 0; w < 8; w++) begin
            if (ref_legal(win[w])) votes[$countones(win[w])]++;
        end
        cls = 0;
        cnt = -1;
        for (int c = 0; c < 8; c++) begin
            if (votes[c] > cnt) begin
                cls = c;
                cnt = votes[c];
            end
        end
        t = (1 << cls) - 1;
        therm = code_t'(t);
    endtask

    function automatic code_t rand_code();
        int k;
        if ($urandom_range(3) == 0) return code_t'($urandom);
        k = (1 << $urandom_range(7)) - 1;
        return code_t'(k);
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input code_t code);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_therm = code;
        @(negedge clk);
        in_valid = 1'b0;
        if (!ref_legal(code)) exp_sticky = 1'b1;
    endtask

    task automatic send_window();
        for (int i = 0; i < 8; i++) send(win[i]);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_sticky = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b required 0", out_valid); end
        checks++; if (illegal_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %0b required 0", illegal_sticky); end
        checks++; if ({out_class, out_count, out_therm} !== 14'd0) begin errors++; $display("FAIL reset_outputs got class=%0d count=%0d therm=%b required 0", out_class, out_count, out_therm); end
        $display("test_reset done");
    endtask

    task automatic test_majority();
        int lat;
        for (int i = 0; i < 8; i++) win[i] = (i < 5) ? 7'b0001111 : 7'b0000111;
        send_window();
        wait_result(lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL maj_latency got %0d required 9", lat); end
        checks++; if (out_class !== 3'd4) begin errors++; $display("FAIL maj_class got %0d required 4", out_class); end
        checks++; if (out_count !== 4'd5) begin errors++; $display("FAIL maj_count got %0d required 5", out_count); end
        checks++; if (out_therm !== 7'b0001111) begin errors++; $display("FAIL maj_therm got %b required 0001111", out_therm); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL maj_hold_in_ready got %0b required 0", in_ready); end
        release_result();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL maj_after_xfer got valid=%0b ready=%0b required 0/1", out_valid, in_ready); end
        $display("test_majority class=%0d count=%0d latency=%0d", out_class, out_count, lat);
    endtask

    task automatic test_tie();
        int lat;
        for (int i = 0; i < 8; i++) win[i] = (i % 2 == 0) ? 7'b0000011 : 7'b0011111;
        send_window();
        wait_result(lat);
        checks++; if (out_class !== 3'd2 || out_count !== 4'd4) begin errors++; $display("FAIL tie_result got class=%0d count=%0d required 2/4", out_class, out_count); end
        checks++; if (out_therm !== 7'b0000011) begin errors++; $display("FAIL tie_therm got %b required 0000011", out_therm); end
        release_result();
        $display("test_tie class=%0d count=%0d", out_class, out_count);
    endtask

    task automatic test_illegal();
        int lat, ecls, ecnt;
        code_t eth;
        for (int i = 0; i < 8; i++) win[i] = (i == 1 || i == 5) ? 7'b0101111 : 7'b0111111;
        send_window();
        wait_result(lat);
        checks++; if (out_class !== 3'd6 || out_count !== 4'd6) begin errors++; $display("FAIL illegal_result got class=%0d count=%0d required 6/6", out_class, out_count); end
        checks++; if (illegal_sticky !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %0b required 1", illegal_sticky); end
        release_result();
        for (int i = 0; i < 8; i++) win[i] = code_t'((1 << $urandom_range(7)) - 1);
        ref_vote(ecls, ecnt, eth);
        send_window();
        wait_result(lat);
        checks++; if (int'(out_class) !== ecls || int'(out_count) !== ecnt) begin errors++; $display("FAIL illegal_next_result got class=%0d count=%0d required %0d/%0d", out_class, out_count, ecls, ecnt); end
        checks++; if (illegal_sticky !== 1'b1) begin errors++; $display("FAIL illegal_sticky_kept got %0b required 1", illegal_sticky); end
        release_result();
        $display("test_illegal sticky=%0b", illegal_sticky);
    endtask

    task automatic test_backpressure();
        int lat, ecls, ecnt;
        code_t eth;
        for (int i = 0; i < 8; i++) win[i] = code_t'((1 << $urandom_range(7)) - 1);
        ref_vote(ecls, ecnt, eth);
        send_window();
        wait_result(lat);
        in_valid = 1'b1;
        in_therm = 7'b1111111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out_class) !== ecls ||
                int'(out_count) !== ecnt || out_therm !== eth) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got valid=%0b ready=%0b class=%0d count=%0d therm=%b required 1/0/%0d/%0d/%b",
                         c, out_valid, in_ready, out_class, out_count, out_therm, ecls, ecnt, eth);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_xfer_valid got %0b required 0", out_valid); end
        for (int i = 0; i < 8; i++) win[i] = rand_code();
        ref_vote(ecls, ecnt, eth);
        send_window();
        wait_result(lat);
        checks++; if (int'(out_class) !== ecls || int'(out_count) !== ecnt || out_therm !== eth) begin errors++; $display("FAIL bp_fresh_window got class=%0d count=%0d therm=%b required %0d/%0d/%b", out_class, out_count, out_therm, ecls, ecnt, eth); end
        release_result();
        $display("test_backpressure class=%0d count=%0d", out_class, out_count);
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        int seen = 0;
        for (int i = 0; i < 8; i++) win[i] = 7'b0101010;
        send_window();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_sticky = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_scan_state got ready=%0b valid=%0b required 1/0", in_ready, out_valid); end
        checks++; if (illegal_sticky !== 1'b0) begin errors++; $display("FAIL rst_scan_sticky got %0b required 0", illegal_sticky); end
        for (int c = 0; c < 14; c++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_scan_no_valid got %0d pulses required 0", seen); end
        for (int i = 0; i < 8; i++) win[i] = 7'b0000001;
        send_window();
        wait_result(lat);
        checks++; if (out_class !== 3'd1 || out_count !== 4'd8 || out_therm !== 7'b0000001) begin errors++; $display("FAIL rst_scan_next got class=%0d count=%0d therm=%b required 1/8/0000001", out_class, out_count, out_therm); end
        release_result();
        $display("test_reset_mid_scan class=%0d count=%0d", out_class, out_count);
    endtask

    task automatic test_random();
        int lat, ecls, ecnt;
        code_t eth;
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < 8; i++) win[i] = rand_code();
            if (w == 7) for (int i = 0; i < 8; i++) win[i] = 7'b1010101;
            ref_vote(ecls, ecnt, eth);
            send_window();
            wait_result(lat);
            checks++;
            if (lat !== 9 || int'(out_class) !== ecls || int'(out_count) !== ecnt ||
                out_therm !== eth || illegal_sticky !== exp_sticky) begin
                errors++;
                $display("FAIL random_window%0d got lat=%0d class=%0d count=%0d therm=%b sticky=%0b required 9/%0d/%0d/%b/%0b",
                         w, lat, out_class, out_count, out_therm, illegal_sticky, ecls, ecnt, eth, exp_sticky);
            end
            $display("random window %0d class=%0d count=%0d", w, out_class, out_count);
            release_result();
        end
    endtask

`ifdef DTC_THERM_VOTE_ERRCNT_EN
    task automatic test_errcnt();
        code_t c;
        out_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            do c = code_t'($urandom); while (ref_legal(c));
            send(c);
        end
        out_ready = 1'b0;
        checks++; if (err_count !== 8'd255 || illegal_sticky !== 1'b1) begin errors++; $display("FAIL errcnt_sat got %0d sticky=%0b required 255/1", err_count, illegal_sticky); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++; if (err_count !== 8'd0 || illegal_sticky !== 1'b0) begin errors++; $display("FAIL errcnt_clear got %0d sticky=%0b required 0/0", err_count, illegal_sticky); end
        clr_err  = 1'b1;
        in_valid = 1'b1;
        in_therm = 7'b0000010;
        @(negedge clk);
        clr_err  = 1'b0;
        in_valid = 1'b0;
        checks++; if (err_count !== 8'd0 || illegal_sticky !== 1'b0) begin errors++; $display("FAIL errcnt_clear_wins got %0d sticky=%0b required 0/0", err_count, illegal_sticky); end
        send(7'b0000100);
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL errcnt_after_clear got %0d required 1", err_count); end
        do_reset();
        $display("test_errcnt done");
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_therm  = '0;
        out_ready = 1'b0;
`ifdef DTC_THERM_VOTE_ERRCNT_EN
        clr_err   = 1'b0;
`endif
        exp_sticky = 1'b0;
        @(negedge clk);
        test_reset();
        test_majority();
        test_tie();
        test_illegal();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
`ifdef DTC_THERM_VOTE_ERRCNT_EN
        test_errcnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
